// File: rtl/l2_pkg.sv
// Shared definitions for the L2 command front-end: trace command codes,
// default geometry and the request-issue FSM state type.
package l2_pkg;

  localparam int ADD_SIZE_DEF    = 32;
  localparam int INDEX_SIZE_DEF  = 14;
  localparam int OFFSET_SIZE_DEF = 6;
  localparam int DEPTH_DEF       = 4;

  localparam logic [3:0] CMD_DATA_READ   = 4'd0;
  localparam logic [3:0] CMD_DATA_WRITE  = 4'd1;
  localparam logic [3:0] CMD_INST_READ   = 4'd2;
  localparam logic [3:0] CMD_SNOOP_INV   = 4'd3;
  localparam logic [3:0] CMD_SNOOP_READ  = 4'd4;
  localparam logic [3:0] CMD_SNOOP_WRITE = 4'd5;
  localparam logic [3:0] CMD_SNOOP_RFO   = 4'd6;
  localparam logic [3:0] CMD_CLEAR       = 4'd8;
  localparam logic [3:0] CMD_PRINT       = 4'd9;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_RSP = 1'b1
  } fe_state_e;

  function automatic logic cmd_supported(input logic [3:0] code);
    return (code <= CMD_SNOOP_RFO) || (code == CMD_CLEAR) || (code == CMD_PRINT);
  endfunction

  // L1-originated accesses are the only ones that wait for an L2 completion.
  function automatic logic cmd_is_l1(input logic [3:0] code);
    return code <= CMD_INST_READ;
  endfunction

  function automatic logic cmd_is_snoop(input logic [3:0] code);
    return (code >= CMD_SNOOP_INV) && (code <= CMD_SNOOP_RFO);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// Request FIFO: power-of-two depth, registered storage, wrap-bit pointers
// so a full FIFO never overwrites an unread entry.
module l2_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/l2_cmd_frontend.sv
// Trace-command front-end for the L2 cache model: decodes and queues commands,
// issues them one at a time to L2, and keeps read/write/hit statistics.
module l2_cmd_frontend
  import l2_pkg::*;
#(
  parameter int ADD_SIZE    = ADD_SIZE_DEF,
  parameter int INDEX_SIZE  = INDEX_SIZE_DEF,
  parameter int OFFSET_SIZE = OFFSET_SIZE_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    cmd_valid,
  input  logic [3:0]                              cmd,
  input  logic [ADD_SIZE-1:0]                     cmd_addr,
  output logic                                    cmd_ready,
  output logic                                    req_valid,
  input  logic                                    req_ready,
  output logic [3:0]                              req_cmd,
  output logic [ADD_SIZE-INDEX_SIZE-OFFSET_SIZE-1:0] req_tag,
  output logic [INDEX_SIZE-1:0]                   req_index,
  output logic [OFFSET_SIZE-1:0]                  req_offset,
  output logic                                    req_snoop,
  input  logic                                    rsp_valid,
  input  logic                                    rsp_hit,
  output logic                                    err_unsup,
  output logic                                    stats_valid,
  output logic [31:0]                             stat_reads,
  output logic [31:0]                             stat_writes,
  output logic [31:0]                             stat_hits
);

  localparam int ENTRY_W = 4 + ADD_SIZE;

  logic               accept, supported, push, pop, full, empty;
  logic [ENTRY_W-1:0] push_entry, head_entry;
  fe_state_e          state_q, state_d;
  logic [31:0]        reads_q, reads_d, writes_q, writes_d, hits_q, hits_d;
  logic [31:0]        stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d;
  logic [31:0]        stat_hits_q, stat_hits_d;
  logic               err_unsup_q, err_unsup_d, stats_valid_q, stats_valid_d;

  assign cmd_ready = !full;
  assign accept    = cmd_valid && cmd_ready;
  assign supported = cmd_supported(cmd);
  assign push      = accept && supported;

  // The address bits are already laid out tag|index|offset, so an entry is just {cmd, addr}.
  always_comb begin
    push_entry = {cmd, cmd_addr};
    if ((cmd == CMD_CLEAR) || (cmd == CMD_PRINT)) begin
      push_entry = {cmd, {ADD_SIZE{1'b0}}};
    end
  end

  l2_req_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty)
  );

  assign {req_cmd, req_tag, req_index, req_offset} = head_entry;
  assign req_snoop = cmd_is_snoop(req_cmd);
  assign req_valid = !empty && (state_q == IDLE);
  assign pop       = req_valid && req_ready;

  always_comb begin
    state_d       = state_q;
    reads_d       = reads_q;
    writes_d      = writes_q;
    hits_d        = hits_q;
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_hits_d   = stat_hits_q;
    err_unsup_d   = accept && !supported;
    stats_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          if (cmd_is_l1(req_cmd)) state_d = WAIT_RSP;
          if ((req_cmd == CMD_DATA_READ) || (req_cmd == CMD_INST_READ)) reads_d = sat_inc(reads_q);
          if (req_cmd == CMD_DATA_WRITE) writes_d = sat_inc(writes_q);
          if (req_cmd == CMD_CLEAR) begin
            stat_reads_d  = reads_q;
            stat_writes_d = writes_q;
            stat_hits_d   = hits_q;
            reads_d       = '0;
            writes_d      = '0;
            hits_d        = '0;
            stats_valid_d = 1'b1;
          end
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          state_d = IDLE;
          if (rsp_hit) hits_d = sat_inc(hits_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      reads_q       <= '0;
      writes_q      <= '0;
      hits_q        <= '0;
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_hits_q   <= '0;
      err_unsup_q   <= 1'b0;
      stats_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      reads_q       <= reads_d;
      writes_q      <= writes_d;
      hits_q        <= hits_d;
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_hits_q   <= stat_hits_d;
      err_unsup_q   <= err_unsup_d;
      stats_valid_q <= stats_valid_d;
    end
  end

  assign err_unsup   = err_unsup_q;
  assign stats_valid = stats_valid_q;
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_hits   = stat_hits_q;

endmodule
